uart_rx_frame_ctrl: RTL and testbench

Receive-side frame controller for the UART Rx path. It detects the start bit, tracks oversampled edges and bit positions, and steers the external 3-sample majority sampler and the 8-bit LSB-first deserializer. It also checks parity and stop bits and issues a one-cycle Data_Valid once the deserializer's P_DATA holds the complete byte.

---
 rtl/uart_rx_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start-bit detect, oversample/bit tracking,
// deserializer strobes, parity/stop checking and a one-cycle Data_Valid.
module uart_rx_frame_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Sampled_Bit,
  output logic [PRESCALE_W-1:0] Edge_Cnt,
  output logic                  Data_Samp_En,
  output logic                  Deser_En,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_q, edge_d;
  logic [PRESCALE_W-1:0]   ps_q, ps_d;
  logic [2:0]              bit_q, bit_d;
  logic                    acc_q, acc_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic                    deser_en;
  logic                    data_valid;
  logic [PRESCALE_W-1:0]   ps_m1;
  logic                    bit_end;

  // Unsupported prescale values still wrap cleanly: PS-1 underflows to all-ones.
  assign ps_m1   = ps_q - PRESCALE_W'(1);
  assign bit_end = (edge_q == ps_m1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      ps_q      <= PRESCALE_W'(8);
      bit_q     <= '0;
      acc_q     <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      ps_q      <= ps_d;
      bit_q     <= bit_d;
      acc_q     <= acc_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_d     = bit_end ? '0 : edge_q + PRESCALE_W'(1);
    ps_d       = ps_q;
    bit_d      = bit_q;
    acc_d      = acc_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    deser_en   = 1'b0;
    data_valid = 1'b0;

    case (state_q)
      IDLE: begin
        edge_d = '0;
        if (!RX_IN) begin
          state_d = START;
          ps_d    = Prescale;
        end
      end
      START: begin
        if (bit_end) begin
          if (Sampled_Bit) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_d     = '0;
            acc_d     = 1'b0;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          deser_en = 1'b1;
          acc_d    = acc_q ^ Sampled_Bit;
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PAR_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (Sampled_Bit != (acc_q ^ PAR_TYP)) begin
            par_err_d = 1'b1;
          end
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!Sampled_Bit) begin
            stp_err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        data_valid = !par_err_q && !stp_err_q;
        // A low line here is the next start bit; this cycle counts as its first.
        if (!RX_IN) begin
          state_d = START;
          ps_d    = Prescale;
          edge_d  = PRESCALE_W'(1);
        end else begin
          state_d = IDLE;
          edge_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
      end
    endcase
  end

  assign Edge_Cnt     = edge_q;
  assign Data_Samp_En = (state_q != IDLE);
  assign Busy         = (state_q != IDLE);
  assign Deser_En     = deser_en;
  assign Data_Valid   = data_valid;
  assign Par_Err      = par_err_q;
  assign Stp_Err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: drives serial frames with an ideal
// mid-bit sampler and a behavioural deserializer, and checks timing and flags.
module tb_uart_rx_frame_ctrl;

  localparam int PW = 6;

  logic          CLK;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          Sampled_Bit;
  logic [PW-1:0] Edge_Cnt;
  logic          Data_Samp_En;
  logic          Deser_En;
  logic          Data_Valid;
  logic          Par_Err;
  logic          Stp_Err;
  logic          Busy;

  uart_rx_frame_ctrl #(.PRESCALE_W(PW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Sampled_Bit  (Sampled_Bit),
    .Edge_Cnt     (Edge_Cnt),
    .Data_Samp_En (Data_Samp_En),
    .Deser_En     (Deser_En),
    .Data_Valid   (Data_Valid),
    .Par_Err      (Par_Err),
    .Stp_Err      (Stp_Err),
    .Busy         (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         ps;
    bit         pen;
    bit         ptyp;
    logic [7:0] data;
    bit         pb;
    bit         sb;
    bit         dv;
    bit         pe;
    bit         se;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic       wave[$];
  int         de_cyc[$];
  int         dv_cyc[$];
  logic [7:0] dv_dat[$];
  int         edge_h[$];
  bit         busy_h[$];
  bit         samp_h[$];
  bit         pe_h[$];
  bit         se_h[$];
  logic [7:0] sr, pipe1, pdata;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int outs_word();
    return int'({Edge_Cnt, Data_Samp_En, Deser_En, Data_Valid, Par_Err, Stp_Err, Busy});
  endfunction

  task automatic add_bit(input int ps, input logic v);
    for (int k = 0; k < ps; k++) wave.push_back(v);
  endtask

  task automatic add_frame(input int ps, input bit pen, input logic [7:0] d,
                           input bit pb, input bit sb);
    add_bit(ps, 1'b0);
    for (int b = 0; b < 8; b++) add_bit(ps, d[b]);
    if (pen) add_bit(ps, pb);
    add_bit(ps, sb);
  endtask

  // Cycle 0 is the first cycle the line is low while the DUT idles.
  task automatic play(input int ps, input int n, input bit scramble);
    int alt;
    alt = (ps == 8) ? 16 : 8;
    de_cyc.delete(); dv_cyc.delete(); dv_dat.delete();
    edge_h.delete(); busy_h.delete(); samp_h.delete(); pe_h.delete(); se_h.delete();
    for (int i = 0; i < n; i++) begin
      RX_IN       = (i < wave.size()) ? wave[i] : 1'b1;
      Sampled_Bit = (i >= ps / 2 && (i - ps / 2) < wave.size()) ? wave[i - ps / 2] : 1'b1;
      Prescale    = (scramble && i > 1) ? PW'(alt) : PW'(ps);
      @(negedge CLK);
      edge_h.push_back(int'(Edge_Cnt));
      busy_h.push_back(Busy);
      samp_h.push_back(Data_Samp_En);
      pe_h.push_back(Par_Err);
      se_h.push_back(Stp_Err);
      if (Deser_En) de_cyc.push_back(i);
      if (Data_Valid) begin
        dv_cyc.push_back(i);
        dv_dat.push_back(pdata);
      end
      pdata = pipe1;
      pipe1 = sr;
      if (Deser_En) sr = {Sampled_Bit, sr[7:1]};
      @(posedge CLK);
      #1;
    end
    RX_IN    = 1'b1;
    Prescale = PW'(ps);
    wave.delete();
  endtask

  task automatic check_frame(input int ps, input bit pen, input bit edv, input bit epe,
                             input bit ese, input logic [7:0] ed);
    int done, bad, first_bad;
    done = 1 + ps * (10 + int'(pen));
    chk("deser_count", de_cyc.size(), 8);
    bad = 0; first_bad = -1;
    foreach (de_cyc[k]) if (de_cyc[k] != ps * (k + 2)) begin
      bad++;
      if (first_bad < 0) first_bad = de_cyc[k];
    end
    chk("deser_timing_bad", bad, 0);
    chk("dv_count", dv_cyc.size(), edv ? 1 : 0);
    if (edv && dv_cyc.size() == 1) begin
      chk("dv_cycle", dv_cyc[0], done);
      chk("dv_pdata", dv_dat[0], ed);
    end
    chk("par_err", pe_h[pe_h.size() - 1], epe);
    chk("stp_err", se_h[se_h.size() - 1], ese);
    bad = 0;
    for (int i = 0; i <= done + 1 && i < edge_h.size(); i++) begin
      bit eb;
      int ee;
      eb = (i >= 1 && i <= done);
      ee = (!eb || i == done) ? 0 : (i - 1) % ps;
      if (busy_h[i] != eb || samp_h[i] != eb || edge_h[i] != ee) bad++;
    end
    chk("edge_busy_seq_bad", bad, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   ps;
    bit   pen, ptyp, pb, sb, epe, ese;
    logic [7:0] d;

    vecs[0] = '{8,  0, 0, 8'hA5, 0, 1, 1, 0, 0};
    vecs[1] = '{16, 1, 0, 8'h5A, 0, 1, 1, 0, 0};
    vecs[2] = '{16, 1, 0, 8'h5A, 1, 1, 0, 1, 0};
    vecs[3] = '{8,  1, 1, 8'h01, 0, 1, 1, 0, 0};
    vecs[4] = '{32, 1, 1, 8'hFF, 0, 1, 0, 1, 0};
    vecs[5] = '{8,  0, 0, 8'h00, 0, 0, 0, 0, 1};
    vecs[6] = '{16, 1, 0, 8'h80, 1, 1, 1, 0, 0};
    vecs[7] = '{8,  1, 1, 8'h01, 1, 0, 0, 1, 1};

    sr = '0; pipe1 = '0; pdata = '0;
    RST = 1'b0; RX_IN = 1'b1; Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
    Sampled_Bit = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs_word(), 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("idle_busy", Busy, 0);
    @(posedge CLK); #1;

    foreach (vecs[v]) begin
      PAR_EN  = vecs[v].pen;
      PAR_TYP = vecs[v].ptyp;
      add_frame(vecs[v].ps, vecs[v].pen, vecs[v].data, vecs[v].pb, vecs[v].sb);
      play(vecs[v].ps, 1 + vecs[v].ps * (10 + int'(vecs[v].pen)) + 4, 1'b1);
      check_frame(vecs[v].ps, vecs[v].pen, vecs[v].dv, vecs[v].pe, vecs[v].se, vecs[v].data);
    end

    // Start glitch: three low cycles then high; flags from the last frame stay set.
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    add_bit(3, 1'b0);
    play(8, 20, 1'b0);
    chk("glitch_busy_mid", busy_h[5], 1);
    chk("glitch_busy_end", busy_h[busy_h.size() - 1], 0);
    chk("glitch_deser", de_cyc.size(), 0);
    chk("glitch_dv", dv_cyc.size(), 0);
    chk("glitch_par_err_kept", pe_h[pe_h.size() - 1], 1);
    chk("glitch_stp_err_kept", se_h[se_h.size() - 1], 1);

    // Flags clear right after the next valid start bit.
    add_frame(8, 0, 8'h96, 0, 1);
    play(8, 86, 1'b0);
    chk("flags_before_start_end", {pe_h[8], se_h[8]}, 2'b11);
    chk("flags_after_start_end", {pe_h[9], se_h[9]}, 2'b00);
    check_frame(8, 0, 1, 0, 0, 8'h96);

    // Back-to-back frames, no idle gap.
    add_frame(32, 0, 8'h3C, 0, 1);
    add_frame(32, 0, 8'hC3, 0, 1);
    play(32, 1 + 640 + 4, 1'b0);
    chk("b2b_dv_count", dv_cyc.size(), 2);
    chk("b2b_deser_count", de_cyc.size(), 16);
    if (dv_cyc.size() == 2) begin
      chk("b2b_dv0_cycle", dv_cyc[0], 321);
      chk("b2b_dv_spacing", dv_cyc[1] - dv_cyc[0], 320);
      chk("b2b_pdata0", dv_dat[0], 8'h3C);
      chk("b2b_pdata1", dv_dat[1], 8'hC3);
    end

    // Asynchronous reset during data bit 4.
    add_frame(8, 0, 8'h55, 0, 1);
    play(8, 44, 1'b0);
    chk("mid_busy", busy_h[43], 1);
    chk("mid_deser_count", de_cyc.size(), 4);
    chk("mid_dv_count", dv_cyc.size(), 0);
    #2 RST = 1'b0;
    #1 chk("mid_reset_outputs", outs_word(), 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    add_frame(8, 0, 8'hFF, 0, 1);
    play(8, 85, 1'b0);
    check_frame(8, 0, 1, 0, 0, 8'hFF);

    // Randomised frames against the rule-level model.
    for (int r = 0; r < 10; r++) begin
      ps   = 8 << $urandom_range(0, 2);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      pb   = 1'($urandom_range(0, 1));
      sb   = ($urandom_range(0, 3) != 0);
      epe  = pen && (pb != ((^d) ^ ptyp));
      ese  = !sb;
      PAR_EN  = pen;
      PAR_TYP = ptyp;
      add_frame(ps, pen, d, pb, sb);
      play(ps, 1 + ps * (10 + int'(pen)) + 4, 1'b1);
      check_frame(ps, pen, !epe && !ese, epe, ese, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
